// File: rtl/msiq_ctrl_pkg.sv
// msiq_ctrl_pkg: shared FSM state type, msiq geometry and the first-set-bit search
package msiq_ctrl_pkg;
  localparam int MSIQ_DEPTH = 8;
  localparam int MSIQ_ADDR_W = 37;
  typedef enum logic [1:0] {RUN, WAIT_Q, CLEAR} state_t;
  function automatic int bit_find_first_bit(input logic [31:0] v);
    bit_find_first_bit = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) bit_find_first_bit = i;
  endfunction
endpackage

// File: rtl/msiq_ctrl_if.sv
// msiq_ctrl_if: requester, flush and msiq-write signals; master drives requests, slave is the controller
interface msiq_ctrl_if import msiq_ctrl_pkg::*; #(
  parameter int NREQ = 3,
  parameter int DEPTH = MSIQ_DEPTH,
  parameter int ADDR_W = MSIQ_ADDR_W
) ();
  localparam int CW = $clog2(DEPTH + 1);
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0] req_vld;
  logic [NREQ-1:0] req_gnt;
  logic flush_req;
  logic quiesce;
  logic [ADDR_W-1:0] wrt_addr;
  logic wrt_en;
  logic wrt_can;
  logic all_clear;
  logic [CW-1:0] count;
  logic busy;
  modport master (
    output req_addr, req_vld, flush_req, quiesce, wrt_can,
    input req_gnt, wrt_addr, wrt_en, all_clear, count, busy
  );
  modport slave (
    input req_addr, req_vld, flush_req, quiesce, wrt_can,
    output req_gnt, wrt_addr, wrt_en, all_clear, count, busy
  );
endinterface

// File: rtl/msiq_ctrl_rr_arb.sv
// rr_arb: round-robin winner over req (idx/vld), pointer moves one past the winner on adv
module rr_arb import msiq_ctrl_pkg::*; #(
  parameter int NREQ = 3,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [IW-1:0]   idx,
  output logic            vld
);
  logic [IW-1:0] ptr;
  logic [NREQ-1:0] rot;
  int w;
  assign rot = NREQ'({req, req} >> ptr);
  assign vld = |req;
  always_comb begin
    w = int'(ptr) + bit_find_first_bit(32'(rot));
    idx = IW'(w >= NREQ ? w - NREQ : w);
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (adv) ptr <= idx == IW'(NREQ - 1) ? '0 : idx + IW'(1);
  end
endmodule

// File: rtl/msiq_ctrl.sv
// msiq_ctrl: arbitrates requester writes into msiq, tracks occupancy, runs flush/clear FSM (ports: clk, rst, bus slave)
module msiq_ctrl import msiq_ctrl_pkg::*; #(
  parameter int NREQ = 3,
  parameter int DEPTH = MSIQ_DEPTH,
  parameter int ADDR_W = MSIQ_ADDR_W
) (
  input logic        clk,
  input logic        rst,
  msiq_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t state, state_nxt;
  logic [IW-1:0] win;
  logic win_vld, en, fire, all_clear, wrt_en;
  logic [ADDR_W-1:0] win_addr, wrt_addr;
  logic [CW-1:0] count, count_nxt;
  logic [NREQ-1:0] gnt;
  // the all_clear cycle is already RUN but msiq is being wiped, so it must not accept a write
  assign en = !rst && state == RUN && !all_clear && count < CW'(DEPTH) && bus.wrt_can;
  assign fire = en && win_vld;
  assign win_addr = bus.req_addr[win*ADDR_W +: ADDR_W];
  assign count_nxt = count + CW'(fire);
  rr_arb #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(bus.req_vld),
    .adv(fire),
    .idx(win),
    .vld(win_vld)
  );
  // requesters carrying the winner's line address ride along on the same write
  for (genvar i = 0; i < NREQ; i++) begin : g_gnt
    assign gnt[i] = fire && bus.req_vld[i] && bus.req_addr[i*ADDR_W +: ADDR_W] == win_addr;
  end
  always_comb begin
    state_nxt = state;
    if (state == RUN) state_nxt = bus.flush_req || count_nxt == CW'(DEPTH) ? WAIT_Q : RUN;
    else if (state == WAIT_Q) state_nxt = bus.quiesce ? CLEAR : WAIT_Q;
    else state_nxt = RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      count <= '0;
      wrt_en <= 1'b0;
      wrt_addr <= '0;
      all_clear <= 1'b0;
    end else begin
      state <= state_nxt;
      all_clear <= state == CLEAR;
      count <= state == CLEAR ? '0 : count_nxt;
      wrt_en <= fire;
      if (fire) wrt_addr <= win_addr;
    end
  end
  assign bus.req_gnt = gnt;
  assign bus.wrt_addr = wrt_addr;
  assign bus.wrt_en = wrt_en;
  assign bus.all_clear = all_clear;
  assign bus.count = count;
  assign bus.busy = state != RUN;
endmodule

// File: tb/tb_msiq_ctrl.sv
// tb_msiq_ctrl: directed self-checking bench for msiq_ctrl with a write-address scoreboard
module tb_msiq_ctrl;
  localparam int NREQ = 3;
  localparam int DEPTH = 8;
  localparam int ADDR_W = 37;
  localparam logic [ADDR_W-1:0] A = 37'h1_0000_0AAA;
  localparam logic [ADDR_W-1:0] B = 37'h0_ABCD_0BBB;
  localparam logic [ADDR_W-1:0] C = 37'h1_F000_0CCC;
  localparam logic [ADDR_W-1:0] D = 37'h0_0000_1234;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [ADDR_W-1:0] exp_q[$];
  msiq_ctrl_if #(.NREQ(NREQ), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();
  msiq_ctrl #(.NREQ(NREQ), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic gnt_is(input string tag, input logic [NREQ-1:0] exp, input logic [ADDR_W-1:0] addr);
    #1;
    chk(tag, 64'(bus.req_gnt), 64'(exp));
    if (exp != '0) exp_q.push_back(addr);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.wrt_en) begin
      chk("wrt_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("wrt_addr", 64'(bus.wrt_addr), 64'(exp_q.pop_front()));
    end
  end
  initial begin
    rst = 1'b1;
    bus.req_addr = {C, B, A};
    bus.req_vld = '0;
    bus.flush_req = 1'b0;
    bus.quiesce = 1'b0;
    bus.wrt_can = 1'b1;
    step();
    step();
    bus.req_vld = 3'b111;
    gnt_is("gnt_in_rst", 3'b000, A);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_wrt_en", 64'(bus.wrt_en), 64'd0);
    chk("rst_wrt_addr", 64'(bus.wrt_addr), 64'd0);
    chk("rst_all_clear", 64'(bus.all_clear), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    step();
    rst = 1'b0;
    gnt_is("rr_g0", 3'b001, A);
    step();
    gnt_is("rr_g1", 3'b010, B);
    step();
    gnt_is("rr_g2", 3'b100, C);
    step();
    bus.req_vld = '0;
    chk("rr_count", 64'(bus.count), 64'd3);
    bus.req_addr = {D, B, D};
    bus.req_vld = 3'b101;
    gnt_is("merge_gnt", 3'b101, D);
    step();
    bus.req_vld = '0;
    gnt_is("merge_idle", 3'b000, D);
    chk("merge_count", 64'(bus.count), 64'd4);
    step();
    chk("hold_wrt_en", 64'(bus.wrt_en), 64'd0);
    chk("hold_wrt_addr", 64'(bus.wrt_addr), 64'(D));
    bus.req_addr = {C, B, A};
    bus.req_vld = 3'b111;
    bus.wrt_can = 1'b0;
    gnt_is("can0_a", 3'b000, A);
    step();
    gnt_is("can0_b", 3'b000, A);
    chk("can0_count", 64'(bus.count), 64'd4);
    bus.wrt_can = 1'b1;
    gnt_is("can1_g1", 3'b010, B);
    step();
    gnt_is("fill_g2", 3'b100, C);
    step();
    gnt_is("fill_g0", 3'b001, A);
    step();
    gnt_is("fill_g1", 3'b010, B);
    step();
    chk("full_count", 64'(bus.count), 64'd8);
    chk("full_busy", 64'(bus.busy), 64'd1);
    gnt_is("full_nogrant", 3'b000, A);
    step();
    gnt_is("waitq_nogrant", 3'b000, A);
    chk("waitq_busy", 64'(bus.busy), 64'd1);
    bus.quiesce = 1'b1;
    step();
    bus.quiesce = 1'b0;
    chk("clear_busy", 64'(bus.busy), 64'd1);
    chk("clear_no_pulse", 64'(bus.all_clear), 64'd0);
    chk("clear_count", 64'(bus.count), 64'd8);
    gnt_is("clear_nogrant", 3'b000, A);
    step();
    chk("ac_pulse", 64'(bus.all_clear), 64'd1);
    chk("ac_count", 64'(bus.count), 64'd0);
    chk("ac_busy", 64'(bus.busy), 64'd0);
    gnt_is("ac_nogrant", 3'b000, A);
    step();
    chk("ac_fall", 64'(bus.all_clear), 64'd0);
    gnt_is("post_clear_g2", 3'b100, C);
    step();
    bus.req_vld = 3'b001;
    gnt_is("pre_flush_g0", 3'b001, A);
    step();
    bus.req_vld = '0;
    chk("pre_flush_count", 64'(bus.count), 64'd2);
    bus.flush_req = 1'b1;
    bus.quiesce = 1'b1;
    gnt_is("flush_nogrant", 3'b000, A);
    step();
    bus.flush_req = 1'b0;
    bus.req_vld = 3'b010;
    chk("flush_busy", 64'(bus.busy), 64'd1);
    gnt_is("flush_waitq", 3'b000, B);
    step();
    chk("flush_clear_ac", 64'(bus.all_clear), 64'd0);
    gnt_is("flush_clear", 3'b000, B);
    step();
    bus.quiesce = 1'b0;
    chk("flush_ac", 64'(bus.all_clear), 64'd1);
    chk("flush_ac_count", 64'(bus.count), 64'd0);
    gnt_is("flush_ac_nogrant", 3'b000, B);
    step();
    chk("flush_ac_fall", 64'(bus.all_clear), 64'd0);
    gnt_is("flush_after_g1", 3'b010, B);
    step();
    bus.req_vld = '0;
    chk("flush_after_count", 64'(bus.count), 64'd1);
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    chk("rstq_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstq_busy0", 64'(bus.busy), 64'd0);
    chk("rstq_count", 64'(bus.count), 64'd0);
    chk("rstq_all_clear", 64'(bus.all_clear), 64'd0);
    chk("rstq_wrt_en", 64'(bus.wrt_en), 64'd0);
    bus.req_vld = 3'b111;
    gnt_is("rstq_ptr0", 3'b001, A);
    step();
    bus.req_vld = '0;
    step();
    step();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
